// File: rtl/jk_counter_reg_pkg.sv
// Shared constants for the JK counter register: operating modes and the
// {j,k} encodings understood by each JK cell.
package jk_counter_reg_pkg;

    // mode_i encodings
    localparam logic [1:0] MODE_JK = 2'b00;
    localparam logic [1:0] MODE_UP = 2'b01;
    localparam logic [1:0] MODE_DN = 2'b10;
    localparam logic [1:0] MODE_LD = 2'b11;

    // {j,k} encodings for a single JK cell
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_counter_reg_jk_cell.sv
// Single-bit JK flip-flop with asynchronous active-high reset to RST_BIT.
module jk_cell
    import jk_counter_reg_pkg::*;
#(
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic j_i,
    input  logic k_i,
    output logic q_o
);

    // JK state update: hold / clear / set / toggle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_o <= RST_BIT;
        end else begin
            case ({j_i, k_i})
                JK_HOLD: q_o <= q_o;
                JK_CLR:  q_o <= 1'b0;
                JK_SET:  q_o <= 1'b1;
                JK_TGL:  q_o <= ~q_o;
            endcase
        end
    end

endmodule

// File: rtl/jk_counter_reg.sv
// WIDTH-bit register of JK cells usable as a plain JK register or as a
// modulo-MODULUS up/down counter with saturating parallel load, sync clear,
// enable, combinational terminal count and a registered wrap pulse.
// In the counting/load modes each cell is forced to the next value by
// driving j=n[b], k=~n[b]; clear drives j=0,k=1 and hold drives j=k=0.
module jk_counter_reg
    import jk_counter_reg_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16,
    parameter int RST_VAL = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] j_i,
    input  logic [WIDTH-1:0] k_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] qn_o,
    output logic             tc_o,
    output logic             wrap_o
);

    // Largest in-range count; fits WIDTH bits even when MODULUS == 2**WIDTH.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_V   = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] nxt;
    logic             wrap_nxt;
    logic [WIDTH-1:0] j_drv;
    logic [WIDTH-1:0] k_drv;

    // Next count value and wrap indication for the non-JK modes
    always_comb begin
        nxt      = q;
        wrap_nxt = 1'b0;
        case (mode_i)
            MODE_UP: begin
                if (q >= MAX_VAL) begin
                    nxt      = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    nxt = q + WIDTH'(1);
                end
            end
            MODE_DN: begin
                if (q == '0) begin
                    nxt      = MAX_VAL;
                    wrap_nxt = 1'b1;
                end else if (q > MAX_VAL) begin
                    // out-of-range value re-enters at the top; not a wrap
                    nxt = MAX_VAL;
                end else begin
                    nxt = q - WIDTH'(1);
                end
            end
            MODE_LD: begin
                nxt = (d_i > MAX_VAL) ? MAX_VAL : d_i;
            end
            default: begin
                nxt = q;
            end
        endcase
    end

    // Per-cell J/K drive: clear beats enable, enable beats mode
    always_comb begin
        j_drv = '0;
        k_drv = '0;
        if (clr_i) begin
            j_drv = '0;
            k_drv = '1;
        end else if (!en_i) begin
            j_drv = '0;
            k_drv = '0;
        end else if (mode_i == MODE_JK) begin
            j_drv = j_i;
            k_drv = k_i;
        end else begin
            j_drv = nxt;
            k_drv = ~nxt;
        end
    end

    for (genvar b = 0; b < WIDTH; b++) begin : g_cell
        jk_cell #(
            .RST_BIT (RST_V[b])
        ) u_cell (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .j_i   (j_drv[b]),
            .k_i   (k_drv[b]),
            .q_o   (q[b])
        );
    end

    // One-cycle wrap pulse following a wrapping edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wrap_o <= 1'b0;
        end else begin
            wrap_o <= wrap_nxt && en_i && !clr_i;
        end
    end

    // Terminal count reflects the pending wrap for the current mode only
    always_comb begin
        tc_o = ((mode_i == MODE_UP) && (q >= MAX_VAL)) ||
               ((mode_i == MODE_DN) && (q == '0));
    end

    assign q_o  = q;
    assign qn_o = ~q;

endmodule

// File: tb/tb_jk_counter_reg.sv
// Self-checking bench for jk_counter_reg (WIDTH=4, MODULUS=10, RST_VAL=5):
// directed scenarios followed by random stimulus against an integer model.
module tb_jk_counter_reg;

    localparam int W = 4;
    localparam int M = 10;
    localparam int R = 5;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         en_i;
    logic         clr_i;
    logic [1:0]   mode_i;
    logic [W-1:0] j_i;
    logic [W-1:0] k_i;
    logic [W-1:0] d_i;
    logic [W-1:0] q_o;
    logic [W-1:0] qn_o;
    logic         tc_o;
    logic         wrap_o;

    int n_chk  = 0;
    int n_pass = 0;

    int m_q    = R;
    int m_wrap = 0;

    jk_counter_reg #(
        .WIDTH   (W),
        .MODULUS (M),
        .RST_VAL (R)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (en_i),
        .clr_i  (clr_i),
        .mode_i (mode_i),
        .j_i    (j_i),
        .k_i    (k_i),
        .d_i    (d_i),
        .q_o    (q_o),
        .qn_o   (qn_o),
        .tc_o   (tc_o),
        .wrap_o (wrap_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h at %0t", tag, act, exp, $time);
    endtask

    // Reference behaviour of one rising edge, from the documented rules.
    task automatic model_edge();
        logic [W-1:0] t;
        if (rst_i) begin
            m_q = R; m_wrap = 0;
        end else if (clr_i) begin
            m_q = 0; m_wrap = 0;
        end else if (!en_i) begin
            m_wrap = 0;
        end else begin
            m_wrap = 0;
            case (mode_i)
                2'd0: begin
                    t = m_q[W-1:0];
                    for (int b = 0; b < W; b++) begin
                        if (j_i[b] && k_i[b]) t[b] = ~t[b];
                        else if (j_i[b])      t[b] = 1'b1;
                        else if (k_i[b])      t[b] = 1'b0;
                    end
                    m_q = int'(t);
                end
                2'd1: begin
                    if (m_q >= M - 1) begin m_q = 0; m_wrap = 1; end
                    else m_q = m_q + 1;
                end
                2'd2: begin
                    if (m_q == 0) begin m_q = M - 1; m_wrap = 1; end
                    else if (m_q > M - 1) m_q = M - 1;
                    else m_q = m_q - 1;
                end
                default: m_q = (int'(d_i) >= M) ? M - 1 : int'(d_i);
            endcase
        end
    endtask

    function automatic logic exp_tc();
        return ((mode_i == 2'd1) && (m_q >= M - 1)) || ((mode_i == 2'd2) && (m_q == 0));
    endfunction

    task automatic check_all(input string tag);
        logic [W-1:0] eq;
        logic [W-1:0] eqn;
        eq  = m_q[W-1:0];
        eqn = ~eq;
        chk({tag, ".q"},    32'(q_o),    32'(eq));
        chk({tag, ".qn"},   32'(qn_o),   32'(eqn));
        chk({tag, ".wrap"}, 32'(wrap_o), 32'(m_wrap));
        chk({tag, ".tc"},   32'(tc_o),   32'(exp_tc()));
    endtask

    task automatic tick(input string tag);
        @(posedge clk_i);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic en, input logic clr, input logic [1:0] mode,
                         input logic [W-1:0] j, input logic [W-1:0] k, input logic [W-1:0] d);
        en_i = en; clr_i = clr; mode_i = mode; j_i = j; k_i = k; d_i = d;
    endtask

    initial begin
        rst_i = 1'b1;
        drive(1'b0, 1'b0, 2'd0, '0, '0, '0);
        repeat (2) @(posedge clk_i);
        #2;
        chk("rst_q", 32'(q_o), 32'd5);
        chk("rst_wrap", 32'(wrap_o), 32'd0);
        rst_i = 1'b0;
        m_q = R; m_wrap = 0;
        tick("idle");

        // up count from 0 through the wrap
        drive(1'b1, 1'b1, 2'd1, '0, '0, '0);
        tick("clr0");
        clr_i = 1'b0;
        for (int i = 0; i < 9; i++) tick("up");
        chk("up9_q", 32'(q_o), 32'd9);
        chk("up9_tc", 32'(tc_o), 32'd1);
        tick("upwrap");
        chk("upwrap_q", 32'(q_o), 32'd0);
        chk("upwrap_pulse", 32'(wrap_o), 32'd1);
        tick("upafter");
        chk("upafter_pulse", 32'(wrap_o), 32'd0);

        // down wrap, then saturating load
        mode_i = 2'd2;
        tick("dn");
        chk("dn_tc", 32'(tc_o), 32'd1);
        tick("dnwrap");
        chk("dnwrap_q", 32'(q_o), 32'd9);
        chk("dnwrap_pulse", 32'(wrap_o), 32'd1);
        drive(1'b1, 1'b0, 2'd3, '0, '0, 4'hC);
        tick("ldsat");
        chk("ldsat_q", 32'(q_o), 32'd9);

        // JK bit operations
        drive(1'b1, 1'b0, 2'd0, 4'b1010, 4'b0101, '0);
        tick("jkset");
        chk("jkset_q", 32'(q_o), 32'hA);
        drive(1'b1, 1'b0, 2'd0, 4'b0101, 4'b1001, '0);
        tick("jkmix");
        chk("jkmix_q", 32'(q_o), 32'h7);

        // out-of-range entry from JK mode
        drive(1'b1, 1'b0, 2'd0, 4'hF, 4'h0, '0);
        tick("jkF");
        mode_i = 2'd2;
        tick("oor_dn");
        chk("oor_dn_q", 32'(q_o), 32'd9);
        chk("oor_dn_wrap", 32'(wrap_o), 32'd0);
        drive(1'b1, 1'b0, 2'd0, 4'hF, 4'h0, '0);
        tick("jkF2");
        mode_i = 2'd1;
        #1;
        chk("oor_up_tc", 32'(tc_o), 32'd1);
        tick("oor_up");
        chk("oor_up_q", 32'(q_o), 32'd0);
        chk("oor_up_wrap", 32'(wrap_o), 32'd1);

        // priority: clear beats disabled enable; disabled enable holds
        drive(1'b1, 1'b0, 2'd3, '0, '0, 4'd7);
        tick("ld7");
        drive(1'b0, 1'b1, 2'd1, '0, '0, '0);
        tick("clr_en0");
        chk("clr_en0_q", 32'(q_o), 32'd0);
        drive(1'b1, 1'b0, 2'd3, '0, '0, 4'd9);
        tick("ld9");
        drive(1'b0, 1'b0, 2'd1, '0, '0, '0);
        tick("hold9");
        chk("hold9_q", 32'(q_o), 32'd9);
        chk("hold9_tc", 32'(tc_o), 32'd1);
        chk("hold9_wrap", 32'(wrap_o), 32'd0);

        // async reset mid-count while a wrap pulse is high
        drive(1'b1, 1'b0, 2'd1, '0, '0, '0);
        tick("wrap_pre_rst");
        #3;
        rst_i = 1'b1;
        #1;
        chk("async_rst_q", 32'(q_o), 32'd5);
        chk("async_rst_wrap", 32'(wrap_o), 32'd0);
        m_q = R; m_wrap = 0;
        tick("rst_held");
        #2;
        rst_i = 1'b0;

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0),
                  2'($urandom_range(0, 3)), W'($urandom), W'($urandom), W'($urandom));
            rst_i = ($urandom_range(0, 99) == 0);
            tick("rnd");
            rst_i = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
